uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 153 +++++++++++++++
 tb/tb_uart_rx.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8E1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM,
// registered byte/valid/error outputs and a break-wait state after a framing error.
`timescale 1ns/1ps

module uart_rx #(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 9600,
    parameter int CYCLES_PER_BAUD  = INPUT_CLOCK_FREQ / BAUD_RATE
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int CW = $clog2(CYCLES_PER_BAUD);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t HALF_BAUD = cnt_t'(CYCLES_PER_BAUD / 2);
    localparam cnt_t LAST_BAUD = cnt_t'(CYCLES_PER_BAUD - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } state_t;

    logic       rx_meta_q, rx_s_q;
    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;

    // Synchronizer resets to the idle-line level so reset never fakes a start edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register sees the pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first; without it a missed branch infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_BAUD) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == LAST_BAUD) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) state_d = PARITY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == LAST_BAUD) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == LAST_BAUD) begin
                    cnt_d   = '0;
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    perr_d  = par_q ^ (^shift_q);
                    ferr_d  = !rx_s_q;
                    state_d = rx_s_q ? IDLE : BREAK_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK_WAIT: begin
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: good frames, parity and
// framing errors, glitch rejection, back-to-back frames and mid-frame reset.
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int CPB = 16;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_parity_err;
    logic       o_frame_err;
    logic       o_busy;

    int n_total = 0;
    int n_bad   = 0;
    int n_stray = 0;
    logic [9:0] rxq[$];

    uart_rx #(.CYCLES_PER_BAUD(CPB)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rx         (i_rx),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_parity_err (o_parity_err),
        .o_frame_err  (o_frame_err),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Every valid cycle is logged; error flags outside a valid cycle are strays.
    always @(negedge i_clk) begin
        if (o_valid) rxq.push_back({o_parity_err, o_frame_err, o_data});
        else if (o_parity_err || o_frame_err) n_stray++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        i_rx = b;
        repeat (CPB) @(negedge i_clk);
    endtask

    task automatic idle(input int n);
        i_rx = 1'b1;
        repeat (n) @(negedge i_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stp);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        logic [9:0] item;
        if (rxq.size() == 0) begin
            check({tag, "_present"}, 0, 1);
        end else begin
            item = rxq.pop_front();
            check({tag, "_data"}, item[7:0], d);
            check({tag, "_perr"}, item[9], pe);
            check({tag, "_ferr"}, item[8], fe);
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_rx  = 1'b1;
        repeat (3) @(negedge i_clk);
        check("rst_data", o_data, 8'h00);
        check("rst_valid", o_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_errs", {o_parity_err, o_frame_err}, 0);
        i_rst = 1'b0;
        idle(20);

        // Good frame
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(4);
        check("a5_cnt", rxq.size(), 1);
        expect_byte("a5", 8'hA5, 1'b0, 1'b0);
        check("a5_busy_after", o_busy, 0);
        idle(20);

        // Wrong parity bit (0x01 needs parity 1)
        send_frame(8'h01, 1'b0, 1'b1);
        idle(4);
        check("par_cnt", rxq.size(), 1);
        expect_byte("par", 8'h01, 1'b1, 1'b0);
        idle(20);

        // Framing error followed by a held-low break
        send_frame(8'h3C, 1'b0, 1'b0);
        i_rx = 1'b0;
        repeat (40) @(negedge i_clk);
        check("fe_cnt", rxq.size(), 1);
        expect_byte("fe", 8'h3C, 1'b0, 1'b1);
        check("fe_busy_break", o_busy, 1);
        idle(4);
        check("fe_busy_release", o_busy, 0);
        idle(16);
        send_frame(8'h7E, 1'b0, 1'b1);
        idle(4);
        check("7e_cnt", rxq.size(), 1);
        expect_byte("7e", 8'h7E, 1'b0, 1'b0);
        idle(20);

        // Short glitch: false start rejected
        i_rx = 1'b0;
        repeat (3) @(negedge i_clk);
        idle(2);
        check("gl_busy", o_busy, 1);
        idle(20);
        check("gl_busy_after", o_busy, 0);
        check("gl_cnt", rxq.size(), 0);
        send_frame(8'h42, 1'b0, 1'b1);
        idle(4);
        check("42_cnt", rxq.size(), 1);
        expect_byte("42", 8'h42, 1'b0, 1'b0);
        idle(20);

        // Back-to-back frames, no idle gap
        send_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b1);
        idle(4);
        check("b2b_cnt", rxq.size(), 2);
        expect_byte("b2b0", 8'h55, 1'b0, 1'b0);
        expect_byte("b2b1", 8'hAA, 1'b0, 1'b0);
        idle(20);

        // Reset during data bit 4 of 0xFF; sender abandons the frame
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        i_rx = 1'b1;
        repeat (CPB / 2) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("mrst_busy", o_busy, 0);
        check("mrst_data", o_data, 8'h00);
        check("mrst_valid", o_valid, 0);
        idle(48);
        check("mrst_cnt", rxq.size(), 0);
        check("mrst_data_hold", o_data, 8'h00);
        send_frame(8'h81, 1'b0, 1'b1);
        idle(4);
        check("81_cnt", rxq.size(), 1);
        expect_byte("81", 8'h81, 1'b0, 1'b0);
        check("81_busy_after", o_busy, 0);

        check("stray_err_pulses", n_stray, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
